arbiter_grant_hold: RTL and testbench

ARBITER_GRANT_HOLD -- requirements
Module: arbiter_grant_hold

---
 rtl/arbiter_grant_hold.sv | 117 +++++++++++
 tb/tb_arbiter_grant_hold.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/arbiter_grant_hold.sv
// Fixed-priority arbiter that holds a grant until the owner drops its request,
// signals done, or (optionally) exhausts a maximum tenure.
module arbiter_grant_hold #(
  parameter int unsigned CLIENTS  = 4,
  parameter int unsigned MAX_HOLD = 0,
  localparam int unsigned IDW     = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [CLIENTS-1:0] i_req,
  input  logic               i_done,
  output logic [CLIENTS-1:0] o_grant,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_grant_valid,
  output logic               o_timeout
);

  localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  typedef enum logic {StIdle, StHeld} state_e;

  state_e             r_state;
  logic [CLIENTS-1:0] r_grant;
  logic [IDW-1:0]     r_grant_id;
  logic               r_grant_valid;
  logic               r_timeout;
  logic [CW-1:0]      r_cnt;

  state_e             w_state_next;
  logic [CLIENTS-1:0] w_grant_next;
  logic [IDW-1:0]     w_grant_id_next;
  logic               w_grant_valid_next;
  logic               w_timeout_next;
  logic [CW-1:0]      w_cnt_next;

  logic [CLIENTS-1:0] w_pick_grant;
  logic [IDW-1:0]     w_pick_id;
  logic               w_owner_req;
  logic               w_expire;
  logic               w_release;

  // Scan from the top so the lowest asserted index wins.
  always_comb begin
    w_pick_grant = '0;
    w_pick_id    = '0;
    for (int i = int'(CLIENTS) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_pick_grant    = '0;
        w_pick_grant[i] = 1'b1;
        w_pick_id       = IDW'(i);
      end
    end
  end

  assign w_owner_req = |(i_req & r_grant);
  assign w_expire    = (MAX_HOLD != 0) && (r_cnt == HOLD_LIM);
  assign w_release   = !w_owner_req || i_done || w_expire;

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_grant_id_next    = r_grant_id;
    w_grant_valid_next = r_grant_valid;
    w_timeout_next     = 1'b0;
    w_cnt_next         = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_next       = StHeld;
          w_grant_next       = w_pick_grant;
          w_grant_id_next    = w_pick_id;
          w_grant_valid_next = 1'b1;
          w_cnt_next         = CW'(1);
        end
      end
      StHeld: begin
        if (w_release) begin
          w_state_next       = StIdle;
          w_grant_next       = '0;
          w_grant_id_next    = '0;
          w_grant_valid_next = 1'b0;
          w_cnt_next         = '0;
          // Timeout flags only a release the counter alone caused.
          w_timeout_next     = w_expire && w_owner_req && !i_done;
        end else if (r_cnt != {CW{1'b1}}) begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_grant_id    <= w_grant_id_next;
      r_grant_valid <= w_grant_valid_next;
      r_timeout     <= w_timeout_next;
      r_cnt         <= w_cnt_next;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_grant_valid = r_grant_valid;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_arbiter_grant_hold.sv
// Directed bench: instance A has no tenure limit, instance B uses MAX_HOLD=3.
module tb_arbiter_grant_hold;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, done_a, rst_b, done_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] id_a, id_b;
  logic       valid_a, valid_b, tout_a, tout_b;

  int n_checks = 0;
  int n_fail   = 0;

  arbiter_grant_hold #(.CLIENTS(4), .MAX_HOLD(0)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_req(req_a), .i_done(done_a),
    .o_grant(grant_a), .o_grant_id(id_a), .o_grant_valid(valid_a), .o_timeout(tout_a)
  );

  arbiter_grant_hold #(.CLIENTS(4), .MAX_HOLD(3)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_req(req_b), .i_done(done_b),
    .o_grant(grant_b), .o_grant_id(id_b), .o_grant_valid(valid_b), .o_timeout(tout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic t);
    check({tag, ".grant"}, 32'(grant_a), 32'(g));
    check({tag, ".id"},    32'(id_a),    32'(id));
    check({tag, ".valid"}, 32'(valid_a), 32'(v));
    check({tag, ".tout"},  32'(tout_a),  32'(t));
  endtask

  task automatic exp_b(input string tag, input logic [3:0] g, input logic v, input logic t);
    check({tag, ".grant"}, 32'(grant_b), 32'(g));
    check({tag, ".valid"}, 32'(valid_b), 32'(v));
    check({tag, ".tout"},  32'(tout_b),  32'(t));
  endtask

  logic [3:0] b_valid_pat;
  logic [3:0] b_tout_pat;

  initial begin
    rst_a = 1'b1; done_a = 1'b0; req_a = 4'b1010;
    rst_b = 1'b1; done_b = 1'b0; req_b = 4'b0000;

    // Reset wins over a pending request.
    step(); exp_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Basic grant, 1-cycle latency.
    rst_a = 1'b0;
    step(); exp_a("basic", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b1011;
    step(); exp_a("nopreempt0", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b1001;
    step(); exp_a("drop1", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); exp_a("regrant0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Client 3 held, client 0 arrives.
    req_a = 4'b0000;
    step(); exp_a("drop0", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); exp_a("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_a = 4'b1000;
    step(); exp_a("grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_a = 4'b1001;
    step(); exp_a("hold3a", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(); exp_a("hold3b", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_a = 4'b0001;
    step(); exp_a("gap3", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); exp_a("after3", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Done release with owner request still high.
    req_a = 4'b0000;
    step(); exp_a("drop0b", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_a = 4'b0100;
    step(); exp_a("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    done_a = 1'b1;
    step(); exp_a("done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done_a = 1'b0;
    step(); exp_a("regrant2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Done in IDLE is ignored.
    req_a = 4'b0000;
    step(); exp_a("drop2", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_a = 4'b0100; done_a = 1'b1;
    step(); exp_a("idle_done", 4'b0100, 2'd2, 1'b1, 1'b0);
    done_a = 1'b0;

    // Reset mid-tenure, then 1-cycle regrant.
    rst_a = 1'b1;
    step(); exp_a("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_a = 1'b0;
    step(); exp_a("rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // No forced release when MAX_HOLD is 0.
    for (int i = 0; i < 8; i++) begin
      step(); exp_a($sformatf("long%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end

    // Instance B: timeout every 3 held cycles.
    req_b = 4'b0001;
    step(); exp_b("b_reset", 4'b0000, 1'b0, 1'b0);
    rst_b = 1'b0;
    b_valid_pat = 4'b0111;
    b_tout_pat  = 4'b1000;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_b($sformatf("b_to%0d_%0d", p, c), b_valid_pat[c] ? 4'b0001 : 4'b0000,
              b_valid_pat[c], b_tout_pat[c]);
      end
    end

    // Done coinciding with expiry: no timeout.
    step(); exp_b("b_h1", 4'b0001, 1'b1, 1'b0);
    step(); exp_b("b_h2", 4'b0001, 1'b1, 1'b0);
    step(); exp_b("b_h3", 4'b0001, 1'b1, 1'b0);
    done_b = 1'b1;
    step(); exp_b("b_done_exp", 4'b0000, 1'b0, 1'b0);
    done_b = 1'b0;

    // Owner drop coinciding with expiry: no timeout.
    step(); exp_b("b_g1", 4'b0001, 1'b1, 1'b0);
    step(); exp_b("b_g2", 4'b0001, 1'b1, 1'b0);
    step(); exp_b("b_g3", 4'b0001, 1'b1, 1'b0);
    req_b = 4'b0000;
    step(); exp_b("b_drop_exp", 4'b0000, 1'b0, 1'b0);
    step(); exp_b("b_idle", 4'b0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
